// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem bus controller and its slot decoder.
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
    localparam logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF;

    // Width of a slot index; a single slot still needs one bit.
    function automatic int slot_idx_w(input int nslots);
        return (nslots > 1) ? $clog2(nslots) : 1;
    endfunction

endpackage

// File: rtl/iomem_bus_ctrl_if.sv
// picosoc iomem master port plus the per-slot peripheral request/response bundle.
interface iomem_bus_ctrl_if #(
    parameter int NSLOTS = 4
);
    logic                   iomem_valid;
    logic [3:0]             iomem_wstrb;
    logic [31:0]            iomem_addr;
    logic [31:0]            iomem_wdata;
    logic                   iomem_ready;
    logic [31:0]            iomem_rdata;
    logic [NSLOTS-1:0]      s_valid;
    logic [3:0]             s_wstrb;
    logic [31:0]            s_addr;
    logic [31:0]            s_wdata;
    logic [NSLOTS-1:0]      s_ready;
    logic [32*NSLOTS-1:0]   s_rdata;

    // Controller view: slave to the CPU, master to the peripherals.
    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, s_ready, s_rdata,
        output iomem_ready, iomem_rdata, s_valid, s_wstrb, s_addr, s_wdata
    );

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, s_ready, s_rdata,
        input  iomem_ready, iomem_rdata, s_valid, s_wstrb, s_addr, s_wdata
    );
endinterface

// File: rtl/iomem_slot_decode.sv
// Combinational slot decode: slot i owns the 16 MB window addr[31:24] == BASE_HI + i.
module iomem_slot_decode #(
    parameter int          NSLOTS  = 4,
    parameter logic [7:0]  BASE_HI = 8'h03
) (
    input  logic [7:0]        addr_hi,
    output logic [NSLOTS-1:0] hit,
    output logic              miss
);

    // One-hot hit vector; windows wrap modulo 256 like the address byte itself.
    always_comb begin
        hit = {NSLOTS{1'b0}};
        for (int i = 0; i < NSLOTS; i++) begin
            hit[i] = (addr_hi == 8'(BASE_HI + i));
        end
        miss = (hit == {NSLOTS{1'b0}});
    end

endmodule

// File: rtl/iomem_bus_ctrl.sv
// Registered iomem bus controller: one outstanding transaction routed to one slot.
// Optional hung-slot timeout is enabled by defining IOMEM_TIMEOUT_EN.
module iomem_bus_ctrl
    import iomem_pkg::*;
#(
    parameter int          NSLOTS  = 4,
    parameter logic [7:0]  BASE_HI = 8'h03,
    parameter int          TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    iomem_bus_ctrl_if.slave  bus,
    output logic             err,
    input  logic             err_clr
);

    localparam int          IW       = slot_idx_w(NSLOTS);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    state_e              state_r, state_nxt_s;
    logic [NSLOTS-1:0]   hit_s;
    logic                miss_s;
    logic [IW-1:0]       hit_idx_s;
    logic [IW-1:0]       slot_r;
    logic [NSLOTS-1:0]   s_valid_r;
    logic [3:0]          s_wstrb_r;
    logic [31:0]         s_addr_r;
    logic [31:0]         s_wdata_r;
    logic [31:0]         rdata_r;
    logic                ready_r;
    logic                err_r;
    logic                err_set_s;
    logic                slot_ready_s;
    logic [31:0]         slot_rdata_s;
    logic                tmo_s;

    iomem_slot_decode #(
        .NSLOTS  (NSLOTS),
        .BASE_HI (BASE_HI)
    ) u_decode (
        .addr_hi (bus.iomem_addr[31:24]),
        .hit     (hit_s),
        .miss    (miss_s)
    );

    // Encode the hit vector and select the active slot's ready and read data.
    always_comb begin
        hit_idx_s    = {IW{1'b0}};
        slot_rdata_s = 32'h0000_0000;
        for (int i = 0; i < NSLOTS; i++) begin
            hit_idx_s    = hit_idx_s | (IW'(i) & {IW{hit_s[i]}});
            slot_rdata_s = slot_rdata_s | (bus.s_rdata[32*i +: 32] & {32{slot_r == IW'(i)}});
        end
        slot_ready_s = |(bus.s_ready & s_valid_r);
    end

`ifdef IOMEM_TIMEOUT_EN
    logic [7:0] cnt_r;

    // Counts ACCESS cycles; held at zero elsewhere so each access starts fresh.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= 8'h00;
        end else if (state_r == ACCESS) begin
            cnt_r <= cnt_r + 8'h01;
        end else begin
            cnt_r <= 8'h00;
        end
    end

    assign tmo_s = (cnt_r == TMO_LAST);
`else
    logic [7:0] unused_tmo_s;
    assign unused_tmo_s = TMO_LAST;
    assign tmo_s        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and error-set strobe; slot ready beats an expiring timeout.
    always_comb begin
        state_nxt_s = state_r;
        err_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.iomem_valid) begin
                    if (miss_s) begin
                        state_nxt_s = RESP;
                        err_set_s   = 1'b1;
                    end else begin
                        state_nxt_s = ACCESS;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (slot_ready_s) begin
                    state_nxt_s = RESP;
                end else if (tmo_s) begin
                    state_nxt_s = RESP;
                    err_set_s   = 1'b1;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request capture, slot strobe, response data and the one-cycle ready pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_r    <= {IW{1'b0}};
            s_valid_r <= {NSLOTS{1'b0}};
            s_wstrb_r <= 4'h0;
            s_addr_r  <= 32'h0000_0000;
            s_wdata_r <= 32'h0000_0000;
            rdata_r   <= 32'h0000_0000;
            ready_r   <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.iomem_valid) begin
                        s_addr_r  <= bus.iomem_addr;
                        s_wdata_r <= bus.iomem_wdata;
                        s_wstrb_r <= bus.iomem_wstrb;
                        slot_r    <= hit_idx_s;
                        s_valid_r <= hit_s;
                        if (miss_s) begin
                            rdata_r <= UNMAPPED_RDATA;
                            ready_r <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (slot_ready_s) begin
                        s_valid_r <= {NSLOTS{1'b0}};
                        rdata_r   <= (s_wstrb_r == 4'h0) ? slot_rdata_s : 32'h0000_0000;
                        ready_r   <= 1'b1;
                    end else if (tmo_s) begin
                        s_valid_r <= {NSLOTS{1'b0}};
                        rdata_r   <= TIMEOUT_RDATA;
                        ready_r   <= 1'b1;
                    end
                end
                default: ready_r <= 1'b0;
            endcase
        end
    end

    // Sticky error flag; a new error in the same cycle beats the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

    assign bus.iomem_ready = ready_r;
    assign bus.iomem_rdata = rdata_r;
    assign bus.s_valid     = s_valid_r;
    assign bus.s_wstrb     = s_wstrb_r;
    assign bus.s_addr      = s_addr_r;
    assign bus.s_wdata     = s_wdata_r;
    assign err             = err_r;

endmodule

// File: doc/iomem_bus_ctrl.md
# iomem_bus_ctrl

Registered bus controller between the picosoc `iomem` master port and up to NSLOTS memory-mapped peripherals (LED, audio, video, and future slots). It replaces the top-level combinational decode and the tied-off `iomem_ready`/`iomem_rdata` with the following:

- a per-transaction state machine that forwards each request to exactly one slot;
- a wait for that slot's ready;
- return of its read data;
- error reporting for unmapped or hung accesses.

## Interface
Parameters:
- NSLOTS, 4: number of peripheral slots (1..8).
- BASE_HI, 8'h03: slot i decodes `iomem_addr[31:24] == BASE_HI + i`.
- TIMEOUT, 255: maximum wait cycles in ACCESS (8-bit counter).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- iomem_valid  in  1  master request, held until `iomem_ready`.
- iomem_wstrb  in  4  byte write strobes; 0 means read.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data.
- iomem_ready  out  1  one-cycle completion pulse.
- iomem_rdata  out  32  read data, valid while `iomem_ready`=1.
- s_valid  out  NSLOTS  one-hot slot request.
- s_wstrb  out  4  registered strobes.
- s_addr  out  32  registered address.
- s_wdata  out  32  registered write data.
- s_ready  in  NSLOTS  per-slot completion.
- s_rdata  in  32*NSLOTS  per-slot read data; slot i occupies bits [32i+31:32i].
- err  out  1  sticky error flag.
- err_clr  in  1  synchronous clear of `err`.

## Operation
States: IDLE, ACCESS, RESP.

- **IDLE:**
  - On `iomem_valid`=1, capture addr, wdata and wstrb into the `s_*` registers and decode the slot.
  - On a hit, go to ACCESS with `s_valid[slot]`=1.
  - On a miss, set `err`, load rdata with UNMAPPED_RDATA = 32'h0000_0000, and go to RESP.
- **ACCESS:**
  - Hold `s_valid[slot]` until `s_ready[slot]`=1.
  - On that cycle, capture the slot's rdata (0 for writes), drop `s_valid`, and go to RESP.
  - `s_ready` bits of non-selected slots are ignored.
- **RESP:**
  - Assert `iomem_ready`=1 for exactly one cycle with the registered rdata, then return to IDLE.
  - `iomem_valid` seen in the following IDLE cycle is treated as a new transaction. picorv32 drops valid on the ready edge.
- **Error flag:**
  - `err` is set on an unmapped access or a timeout, and is cleared by `err_clr`.
  - Set wins over clear in the same cycle.
- **Protocol violation:** if `iomem_valid` drops during ACCESS, the transaction still completes to the slot and the RESP pulse is still issued.
- **Reset:** all outputs are 0 (`iomem_ready`, `iomem_rdata`, `s_valid`, `s_wstrb`, `s_addr`, `s_wdata`, `err`) and the state is IDLE. Asserting `resetn` mid-ACCESS drops `s_valid` immediately (asynchronously).

## Timing
- Cycle numbering: `iomem_valid` first sampled at edge 0.
- Mapped access with `s_ready` high in the first ACCESS cycle:
  - `s_valid` is high during cycle 1;
  - `iomem_ready` is high during cycle 2;
  - minimum latency is 2 cycles.
- Each extra slot wait cycle adds 1 cycle.
- Unmapped access: `iomem_ready` is high during cycle 1.
- Only one transaction is outstanding; there is no pipelining.
- `s_addr`, `s_wdata` and `s_wstrb` are stable for the entire ACCESS phase.

## Configuration
- **IOMEM_TIMEOUT_EN defined:**
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle.
  - When the count equals TIMEOUT without `s_ready`, the block drops `s_valid`, sets `err`, loads TIMEOUT_RDATA = 32'hFFFF_FFFF, and goes to RESP.
  - If `s_ready` arrives in the same cycle as expiry, ready wins: normal completion, no error.
- **IOMEM_TIMEOUT_EN undefined:**
  - There is no counter and ACCESS waits indefinitely.
  - `err` is set only by unmapped accesses.

## Structure
- Package `iomem_pkg`:
  - state enum (IDLE/ACCESS/RESP);
  - UNMAPPED_RDATA and TIMEOUT_RDATA constants;
  - the slot-index width function.
- Sub-module `iomem_slot_decode`:
  - combinational decode of addr[31:24] and BASE_HI;
  - outputs a one-hot NSLOTS hit vector and a miss flag.
- The state machine, registers and timeout counter live in `iomem_bus_ctrl`.

## Test plan
- Read addr 0x0400_0010 with slot 1 `s_ready` held high and rdata 0x1234_5678 -> `s_valid`=4'b0010 for 1 cycle; `iomem_ready` at cycle 2 with rdata 0x1234_5678; `err`=0.
- Write 0x0500_0000, wdata 0xA5, wstrb 4'hF, slot 2 ready after 5 wait cycles -> `s_wdata`/`s_addr` stable for 6 ACCESS cycles; `iomem_ready` at cycle 7 with rdata 0.
- Read unmapped 0x0900_0000 -> no `s_valid`; `iomem_ready` at cycle 1 with rdata 0; `err`=1; `err_clr` pulse -> `err`=0.
- With IOMEM_TIMEOUT_EN and TIMEOUT=16, slot 0 never ready -> `s_valid` drops after 16 cycles; `iomem_ready` with 0xFFFF_FFFF; `err`=1. Then `s_ready` arriving exactly at expiry -> normal data, `err` unchanged.
- Back-to-back reads with `iomem_valid` reasserted in the cycle after `iomem_ready` -> two distinct transactions, no duplicate `s_valid` pulse.
- `resetn` low during ACCESS -> `s_valid`, `iomem_ready` and `err` go to 0 immediately; the next transaction after release completes normally.
